adc_sample_scheduler: RTL and testbench
=======================================

Name: adc_sample_scheduler

Overview:
- Owns the single write port of the shared data RAM.
- Schedules periodic EMG/ECG sample writes into two circular buffers and arbitrates them against processor stores; the processor always wins.
- Sits between the processor/ADC capture logic and the data RAM write port, replacing ad-hoc sample-timing logic.
- Exposes write pointers and wrap pulses so the VGA path and software know buffer position.

Parameters:
- SAMPLE_INTERVAL, 125000, clock cycles between sample ticks (channels alternate, so each channel is sampled every 2×interval).
- CNT_W, 18, width of interval counter; must hold SAMPLE_INTERVAL-1.
- DEPTH, 640, samples per channel ring buffer.
- PTR_W, 10, pointer width; 2^PTR_W ≥ DEPTH.
- ADDR_W, 12, RAM word address width.
- DATA_W, 32, sample/RAM data width.
- EMG_BASE, 12'h400, word address of EMG buffer slot 0.
- ECG_BASE, 12'h680, word address of ECG buffer slot 0; [EMG_BASE, EMG_BASE+DEPTH) and [ECG_BASE, ECG_BASE+DEPTH) must not overlap.

Ports:
- clock  input  1  system clock (35 MHz domain).
- reset  input  1  synchronous, active-low reset.
- enable  input  1  sampling enable; timer runs only when high.
- emg_in  input  DATA_W  current EMG conversion result.
- ecg_in  input  DATA_W  current ECG conversion result.
- cpu_wren  input  1  processor store request.
- cpu_addr  input  ADDR_W  processor store address.
- cpu_data  input  DATA_W  processor store data.
- ram_wren  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM write address.
- ram_din  output  DATA_W  RAM write data.
- adc_grant  output  1  high in the cycle a sample is written.
- emg_ptr  output  PTR_W  next EMG slot to be written.
- ecg_ptr  output  PTR_W  next ECG slot to be written.
- emg_wrap  output  1  one-cycle pulse when emg_ptr wraps DEPTH-1→0.
- ecg_wrap  output  1  one-cycle pulse when ecg_ptr wraps DEPTH-1→0.
- overrun_cnt  output  8  dropped-tick count, saturating at 255.
- pending  output  1  a latched sample is awaiting the port.

Behaviour:
- Reset (reset=0 at a clock edge):
  - Counter, pointers, overrun_cnt cleared to 0.
  - Channel select returns to EMG; state returns to IDLE.
  - Any pending sample is discarded.
  - emg_wrap, ecg_wrap, adc_grant, pending all 0.
  - While reset is low, ram_wren is forced to 0.
- Timer:
  - When enable=1, the counter counts 0..SAMPLE_INTERVAL-1 and wraps.
  - tick is asserted in the cycle where counter == SAMPLE_INTERVAL-1.
  - When enable=0, the counter holds at 0 and no tick occurs; a pending sample still completes.
- State machine, states IDLE and PEND:
  - IDLE + tick: latch the selected channel's input into sample_q and base+ptr into addr_q on that edge, then go to PEND.
  - PEND + cpu_wren=0: adc_grant=1 and ram_wren=1 with addr_q/sample_q. On that edge:
    - advance the selected pointer;
    - toggle the channel;
    - go to IDLE.
  - PEND + cpu_wren=1: remain in PEND. The sample is never lost to contention, only delayed.
- Port mux is combinational, with zero latency for the processor:
  - cpu_wren=1 → ram_* = cpu_*.
  - Otherwise, in PEND → ram_* = sample write.
  - Otherwise ram_wren=0, and ram_addr/ram_din = cpu_addr/cpu_data.
- Minimum latency is tick edge → RAM write in the next cycle.
- Overrun:
  - A tick arriving while in PEND is dropped, and overrun_cnt increments (saturating).
  - The pending sample, channel and pointers are unaffected by the dropped tick.
- Pointer rules:
  - A pointer advances ptr+1, or goes to 0 when ptr == DEPTH-1; a pointer never reaches DEPTH.
  - The wrap pulse is asserted in the cycle after the wrapping write.
- Channel order is strictly EMG, ECG, EMG, … and counts only completed writes.
- emg_ptr and ecg_ptr are registered outputs.

Decomposition:
- Package adc_sched_pkg holds:
  - state enum {IDLE, PEND};
  - channel enum {CH_EMG, CH_ECG};
  - default EMG_BASE, ECG_BASE, DEPTH and SAMPLE_INTERVAL constants, shared with the RAM and VGA blocks.
- One natural sub-module, sample_interval_timer: counter plus tick output, parameterized by SAMPLE_INTERVAL and CNT_W, with enable and synchronous active-low reset.
- FSM, pointers and mux stay in the top module.

Test Plan:
- All tests use SAMPLE_INTERVAL=8 and DEPTH=4 unless noted.
- Basic sequence: enable=1, emg_in=0xAAAA, ecg_in=0x5555, cpu_wren=0 → writes in this order, each one cycle after its tick, adc_grant=1 only on those cycles:
  - 0x5555_or_AAAA pattern: EMG 0xAAAA at 0x400, ECG 0x5555 at 0x680, EMG at 0x401, ECG at 0x681.
- Contention: hold cpu_wren=1 (addr 0x010, data 0x1234) for 3 cycles after a tick → RAM sees 3 CPU writes, then the sample write on the 4th cycle; pending=1 for 3 cycles; overrun_cnt stays 0.
- Overrun: hold cpu_wren=1 for 10 cycles across a second tick → overrun_cnt=1; exactly one sample written after release; the channel toggles once.
- Wrap: run 8 completed writes → emg_ptr sequence 0,1,2,3,0; one emg_wrap pulse after the EMG write to 0x403; next EMG write goes to 0x400.
- Reset mid-operation: assert reset=0 while in PEND → no sample write occurs; ram_wren=0 during reset; after release, pointers=0, overrun_cnt=0, and the first write is EMG at 0x400.
- Disable: drop enable mid-interval → no further ticks; a sample already pending completes; re-enable → the next tick arrives SAMPLE_INTERVAL cycles later.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: types and default constants shared by the ADC sample
// scheduler, the data RAM and the VGA read path.
//   state_e  : scheduler FSM state (IDLE, PEND)
//   chan_e   : channel currently due for a sample (CH_EMG, CH_ECG)
//   *_DEF    : default buffer placement and sample timing
package adc_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  typedef enum logic {
    CH_EMG = 1'b0,
    CH_ECG = 1'b1
  } chan_e;

  localparam int unsigned SAMPLE_INTERVAL_DEF = 125000;
  localparam int unsigned DEPTH_DEF           = 640;
  localparam logic [11:0] EMG_BASE_DEF        = 12'h400;
  localparam logic [11:0] ECG_BASE_DEF        = 12'h680;

endpackage

// File: rtl/sample_interval_timer.sv
// sample_interval_timer: free-running interval counter that produces one
// tick every SAMPLE_INTERVAL enabled cycles.
//   clock  : system clock
//   reset  : synchronous, active-low reset
//   enable : counter runs only while high; held at 0 otherwise
//   tick   : high in the cycle the counter sits at SAMPLE_INTERVAL-1
module sample_interval_timer
  import adc_sched_pkg::*;
#(
  parameter int unsigned SAMPLE_INTERVAL = SAMPLE_INTERVAL_DEF,
  parameter int unsigned CNT_W           = 18
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(SAMPLE_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!enable || (cnt_q == TC)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Gated with enable so that dropping enable in the terminal cycle
  // cannot leak a tick.
  assign tick = enable && (cnt_q == TC);

endmodule

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: owns the data RAM write port. Periodically latches
// an EMG or ECG sample (alternating) and writes it into that channel's
// ring buffer, yielding the port to processor stores, which always win.
//   clock, reset          : system clock, synchronous active-low reset
//   enable                : sampling enable
//   emg_in, ecg_in        : current conversion results
//   cpu_wren/addr/data    : processor store request
//   ram_wren/addr/din     : RAM write port
//   adc_grant             : high in the cycle a sample is written
//   emg_ptr, ecg_ptr      : next slot to be written per channel
//   emg_wrap, ecg_wrap    : one-cycle pulse after a wrapping write
//   overrun_cnt           : ticks dropped while a sample was pending (sat.)
//   pending               : a latched sample is waiting for the port
//
// state | meaning
// IDLE  | no sample held; waiting for the next tick
// PEND  | sample latched in sample_q/addr_q; written on first cycle
//       | without a processor store
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned        SAMPLE_INTERVAL = SAMPLE_INTERVAL_DEF,
  parameter int unsigned        CNT_W           = 18,
  parameter int unsigned        DEPTH           = DEPTH_DEF,
  parameter int unsigned        PTR_W           = 10,
  parameter int unsigned        ADDR_W          = 12,
  parameter int unsigned        DATA_W          = 32,
  parameter logic [ADDR_W-1:0]  EMG_BASE        = EMG_BASE_DEF,
  parameter logic [ADDR_W-1:0]  ECG_BASE        = ECG_BASE_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] emg_in,
  input  logic [DATA_W-1:0] ecg_in,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              adc_grant,
  output logic [PTR_W-1:0]  emg_ptr,
  output logic [PTR_W-1:0]  ecg_ptr,
  output logic              emg_wrap,
  output logic              ecg_wrap,
  output logic [7:0]        overrun_cnt,
  output logic              pending
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic              tick;
  state_e            state_q;
  chan_e             chan_q;
  logic [PTR_W-1:0]  emg_ptr_q, emg_ptr_d;
  logic [PTR_W-1:0]  ecg_ptr_q, ecg_ptr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sample_q;
  logic              emg_wrap_q, ecg_wrap_q;
  logic [7:0]        overrun_q;

  sample_interval_timer #(
    .SAMPLE_INTERVAL (SAMPLE_INTERVAL),
    .CNT_W           (CNT_W)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign emg_ptr_d = (emg_ptr_q == PTR_LAST) ? '0 : emg_ptr_q + PTR_W'(1);
  assign ecg_ptr_d = (ecg_ptr_q == PTR_LAST) ? '0 : ecg_ptr_q + PTR_W'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      chan_q     <= CH_EMG;
      emg_ptr_q  <= '0;
      ecg_ptr_q  <= '0;
      addr_q     <= '0;
      sample_q   <= '0;
      emg_wrap_q <= 1'b0;
      ecg_wrap_q <= 1'b0;
      overrun_q  <= '0;
    end else begin
      emg_wrap_q <= 1'b0;
      ecg_wrap_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= PEND;
            if (chan_q == CH_EMG) begin
              sample_q <= emg_in;
              addr_q   <= EMG_BASE + ADDR_W'(emg_ptr_q);
            end else begin
              sample_q <= ecg_in;
              addr_q   <= ECG_BASE + ADDR_W'(ecg_ptr_q);
            end
          end
        end
        PEND: begin
          // A tick here has no slot to go to; it is counted and dropped
          // without disturbing the sample already held.
          if (tick && (overrun_q != 8'hFF)) begin
            overrun_q <= overrun_q + 8'd1;
          end
          if (!cpu_wren) begin
            state_q <= IDLE;
            if (chan_q == CH_EMG) begin
              emg_ptr_q  <= emg_ptr_d;
              emg_wrap_q <= (emg_ptr_q == PTR_LAST);
              chan_q     <= CH_ECG;
            end else begin
              ecg_ptr_q  <= ecg_ptr_d;
              ecg_wrap_q <= (ecg_ptr_q == PTR_LAST);
              chan_q     <= CH_EMG;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Zero-latency port mux; reset input gates the enable so nothing is
  // written while reset is held, even by the processor.
  always_comb begin
    ram_wren = 1'b0;
    ram_addr = cpu_addr;
    ram_din  = cpu_data;
    if (cpu_wren) begin
      ram_wren = reset;
    end else if (state_q == PEND) begin
      ram_wren = reset;
      ram_addr = addr_q;
      ram_din  = sample_q;
    end
  end

  assign adc_grant   = reset && (state_q == PEND) && !cpu_wren;
  assign emg_ptr     = emg_ptr_q;
  assign ecg_ptr     = ecg_ptr_q;
  assign emg_wrap    = emg_wrap_q;
  assign ecg_wrap    = ecg_wrap_q;
  assign overrun_cnt = overrun_q;
  assign pending     = (state_q == PEND);

endmodule

// File: tb/tb_adc_sample_scheduler.sv
module tb_adc_sample_scheduler;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int PTR_W  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [DATA_W-1:0] emg_in, ecg_in;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              adc_grant;
  logic [PTR_W-1:0]  emg_ptr, ecg_ptr;
  logic              emg_wrap, ecg_wrap;
  logic [7:0]        overrun_cnt;
  logic              pending;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  always #5 clock = ~clock;

  adc_sample_scheduler #(
    .SAMPLE_INTERVAL (8),
    .CNT_W           (4),
    .DEPTH           (4),
    .PTR_W           (PTR_W),
    .ADDR_W          (ADDR_W),
    .DATA_W          (DATA_W),
    .EMG_BASE        (12'h400),
    .ECG_BASE        (12'h680)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .emg_in      (emg_in),
    .ecg_in      (ecg_in),
    .cpu_wren    (cpu_wren),
    .cpu_addr    (cpu_addr),
    .cpu_data    (cpu_data),
    .ram_wren    (ram_wren),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .adc_grant   (adc_grant),
    .emg_ptr     (emg_ptr),
    .ecg_ptr     (ecg_ptr),
    .emg_wrap    (emg_wrap),
    .ecg_wrap    (ecg_wrap),
    .overrun_cnt (overrun_cnt),
    .pending     (pending)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to 4 time units after the next rising edge; cyc numbers the
  // cycle counted from the last reset release (cycle 0 has counter = 0).
  task automatic step();
    @(posedge clock);
    #4;
    cyc++;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    cpu_wren = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    cyc   = 0;
    #1;
  endtask

  logic [11:0] exp_addr [9] = '{12'h400, 12'h680, 12'h401, 12'h681, 12'h402,
                                12'h682, 12'h403, 12'h683, 12'h400};
  logic [1:0]  exp_eptr [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gi, bad_cyc, g, first;
    int ewrap_q[$];
    int cwrap_q[$];

    enable   = 1'b1;
    emg_in   = 32'h0000_AAAA;
    ecg_in   = 32'h0000_5555;
    cpu_wren = 1'b0;
    cpu_addr = 12'h010;
    cpu_data = 32'h1234;
    reset    = 1'b0;

    // ---------------- reset state ----------------
    step();
    cpu_wren = 1'b1;
    #1;
    check_val("rst_ram_wren", ram_wren, 0);
    do_reset();
    check_val("rst_emg_ptr", emg_ptr, 0);
    check_val("rst_ecg_ptr", ecg_ptr, 0);
    check_val("rst_overrun", overrun_cnt, 0);
    check_val("rst_pending", pending, 0);
    check_val("rst_grant", adc_grant, 0);
    check_val("rst_wraps", {emg_wrap, ecg_wrap}, 0);

    // ---------------- basic sequence and wrap ----------------
    gi = 0;
    bad_cyc = 0;
    for (int c = 1; c <= 73; c++) begin
      step();
      if (ram_wren !== adc_grant || pending !== adc_grant) bad_cyc++;
      if (adc_grant === 1'b1) begin
        if (gi < 9) begin
          check_val("seq_cycle", c, 8 * (gi + 1));
          check_val("seq_addr", ram_addr, exp_addr[gi]);
          check_val("seq_data", ram_din, (gi % 2 == 0) ? 32'hAAAA : 32'h5555);
          if (gi % 2 == 0) check_val("seq_emg_ptr", emg_ptr, exp_eptr[gi / 2]);
        end
        gi++;
      end
      if (emg_wrap === 1'b1) ewrap_q.push_back(c);
      if (ecg_wrap === 1'b1) cwrap_q.push_back(c);
    end
    check_val("seq_grant_count", gi, 9);
    check_val("seq_port_consistency", bad_cyc, 0);
    check_val("emg_wrap_count", ewrap_q.size(), 1);
    if (ewrap_q.size() > 0) check_val("emg_wrap_cycle", ewrap_q[0], 57);
    check_val("ecg_wrap_count", cwrap_q.size(), 1);
    if (cwrap_q.size() > 0) check_val("ecg_wrap_cycle", cwrap_q[0], 65);
    check_val("seq_end_emg_ptr", emg_ptr, 1);
    check_val("seq_end_ecg_ptr", ecg_ptr, 0);

    // ---------------- contention ----------------
    do_reset();
    repeat (7) step();
    check_val("cont_pre_tick_pending", pending, 0);
    step();                                          // cycle 8
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      cpu_wren = 1'b1;
      #1;
      check_val("cont_cpu_wren", ram_wren, 1);
      check_val("cont_cpu_addr", ram_addr, 12'h010);
      check_val("cont_cpu_data", ram_din, 32'h1234);
      check_val("cont_no_grant", adc_grant, 0);
      check_val("cont_pending", pending, 1);
    end
    step();                                          // cycle 11
    cpu_wren = 1'b0;
    #1;
    check_val("cont_sample_grant", adc_grant, 1);
    check_val("cont_sample_wren", ram_wren, 1);
    check_val("cont_sample_addr", ram_addr, 12'h400);
    check_val("cont_sample_data", ram_din, 32'hAAAA);
    step();                                          // cycle 12
    check_val("cont_after_pending", pending, 0);
    check_val("cont_after_emg_ptr", emg_ptr, 1);
    check_val("cont_overrun", overrun_cnt, 0);

    // ---------------- overrun ----------------
    repeat (4) step();                               // cycle 16, ECG pending
    for (int c = 16; c <= 25; c++) begin
      if (c > 16) step();
      cpu_wren = 1'b1;
      #1;
      if (c == 22) check_val("ovr_before_tick", overrun_cnt, 0);
    end
    check_val("ovr_count", overrun_cnt, 1);
    check_val("ovr_pending", pending, 1);
    check_val("ovr_no_grant", adc_grant, 0);
    step();                                          // cycle 26
    cpu_wren = 1'b0;
    #1;
    check_val("ovr_release_grant", adc_grant, 1);
    check_val("ovr_release_addr", ram_addr, 12'h680);
    check_val("ovr_release_data", ram_din, 32'h5555);
    g = 0;
    for (int c = 27; c <= 32; c++) begin
      step();
      if (c == 27) begin
        check_val("ovr_after_pending", pending, 0);
        check_val("ovr_after_ecg_ptr", ecg_ptr, 1);
        check_val("ovr_after_emg_ptr", emg_ptr, 1);
      end
      if (c < 32 && adc_grant === 1'b1) g++;
    end
    check_val("ovr_no_extra_write", g, 0);
    check_val("ovr_next_grant", adc_grant, 1);
    check_val("ovr_next_addr", ram_addr, 12'h401);
    check_val("ovr_count_held", overrun_cnt, 1);

    // ---------------- reset while pending ----------------
    repeat (8) step();                               // cycle 40, PEND
    check_val("rmid_pre_pending", pending, 1);
    reset = 1'b0;
    #1;
    check_val("rmid_no_sample_wren", ram_wren, 0);
    check_val("rmid_no_grant", adc_grant, 0);
    step();
    cpu_wren = 1'b1;
    #1;
    check_val("rmid_cpu_blocked", ram_wren, 0);
    step();
    cpu_wren = 1'b0;
    reset    = 1'b1;
    cyc      = 0;
    #1;
    check_val("rmid_emg_ptr", emg_ptr, 0);
    check_val("rmid_ecg_ptr", ecg_ptr, 0);
    check_val("rmid_overrun", overrun_cnt, 0);
    check_val("rmid_pending", pending, 0);
    check_val("rmid_ram_wren", ram_wren, 0);
    g = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c < 8 && adc_grant === 1'b1) g++;
    end
    check_val("rmid_early_writes", g, 0);
    check_val("rmid_first_grant", adc_grant, 1);
    check_val("rmid_first_addr", ram_addr, 12'h400);
    check_val("rmid_first_data", ram_din, 32'hAAAA);

    // ---------------- disable ----------------
    repeat (8) step();                               // cycle 16, ECG pending
    enable   = 1'b0;
    cpu_wren = 1'b1;
    #1;
    check_val("dis_pending", pending, 1);
    step();                                          // cycle 17
    cpu_wren = 1'b0;
    #1;
    check_val("dis_complete_grant", adc_grant, 1);
    check_val("dis_complete_addr", ram_addr, 12'h680);
    check_val("dis_complete_data", ram_din, 32'h5555);
    g = 0;
    for (int c = 18; c <= 38; c++) begin
      step();
      if (adc_grant === 1'b1 || pending === 1'b1) g++;
    end
    check_val("dis_no_activity", g, 0);
    enable = 1'b1;                                   // re-enabled in cycle 38
    first = -1;
    for (int c = 39; c <= 50; c++) begin
      step();
      if (adc_grant === 1'b1 && first < 0) begin
        first = c;
        check_val("reen_addr", ram_addr, 12'h401);
      end
    end
    check_val("reen_first_write_cycle", first, 46);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
